// File: rtl/mips_io_port_responder.sv
// ============================================================================
// Module  : mips_io_port_responder
// Brief   : Memory-mapped I/O responder. Byte FIFO to PortOut with a paced
//           drain, and a synchronized PortIn with a sticky change flag.
//           Optional interrupt output enabled by macro MIPS_IO_IRQ_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_io_port_responder #(
  parameter logic [31:0] IO_BASE    = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          PORT_WIDTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [31:0]           Address,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  MemHit,
  input  logic [PORT_WIDTH-1:0] PortIn,
  output logic [PORT_WIDTH-1:0] PortOut
`ifdef MIPS_IO_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = FIFO_DEPTH[AW:0];

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]            state, state_next;
  logic [15:0]           pc;
  logic [15:0]           divisor;
  logic [PORT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic [PORT_WIDTH-1:0] s1, s2, s3;
  logic                  in_changed, overflow;
  logic [31:0]           status, ctrl_rd, rdata_sel;
  logic                  pop, pc_dec;
  logic                  unused_bits;

  wire [1:0] offset    = Address[3:2];
  wire       empty     = (count == '0);
  wire       full      = (count == FULL_COUNT);
  wire       write_op  = MemHit & MemWrite;
  // A simultaneous store suppresses any read side effect.
  wire       read_op   = MemHit & MemRead & ~MemWrite;
  wire       push_req  = write_op & (offset == 2'd0);
  wire       ctrl_wr   = write_op & (offset == 2'd3);
  wire       status_rd = read_op & (offset == 2'd2);
  wire       do_push   = push_req & (~full | pop);
  wire       ovf_set   = push_req & full & ~pop;

  assign MemHit      = (Address[31:4] == IO_BASE[31:4]);
  assign unused_bits = ^{Address[1:0], WriteData[31:16]};

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty && divisor != 16'd0) state_next = WAIT;
      WAIT:    if (pc == 16'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop    = 1'b0;
    pc_dec = 1'b0;
    case (state)
      IDLE:    pop    = !empty;
      WAIT:    pc_dec = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && do_push) mem[wr_ptr] <= WriteData[PORT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      PortOut    <= '0;
      pc         <= 16'd0;
      divisor    <= DIV_RESET;
      s1         <= '0;
      s2         <= '0;
      s3         <= '0;
      in_changed <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        PortOut <= mem[rd_ptr];
        pc      <= divisor;
      end else if (pc_dec) begin
        pc <= pc - 16'd1;
      end
      if (do_push && !pop)      count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
      if (ctrl_wr) divisor <= WriteData[15:0];
      s1 <= PortIn;
      s2 <= s1;
      s3 <= s2;
      // Set events take priority over the read-to-clear.
      in_changed <= (s2 != s3) | (in_changed & ~status_rd);
      overflow   <= ovf_set | (overflow & ~status_rd);
    end
  end

`ifdef MIPS_IO_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= WriteData[16];
      irq <= irq_en & (in_changed | overflow);
    end
  end

  assign ctrl_rd = {15'd0, irq_en, divisor};
`else
  assign ctrl_rd = {16'd0, divisor};
`endif

  assign status = {19'd0, 5'(count), 4'd0, overflow, in_changed, full, empty};

  always_comb begin
    rdata_sel = 32'd0;
    case (offset)
      2'd0:    rdata_sel = 32'(PortOut);
      2'd1:    rdata_sel = 32'(s2);
      2'd2:    rdata_sel = status;
      default: rdata_sel = ctrl_rd;
    endcase
  end

  assign ReadData = (MemHit && MemRead) ? rdata_sel : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mips_io_port_responder.sv
// ============================================================================
// Module  : tb_mips_io_port_responder
// Brief   : Directed and randomized bench for mips_io_port_responder with a
//           queue-based reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mips_io_port_responder;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead;
  logic [31:0] Address, WriteData, ReadData;
  logic        MemHit;
  logic [7:0]  PortIn, PortOut;
`ifdef MIPS_IO_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  mips_io_port_responder dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .MemHit(MemHit), .PortIn(PortIn), .PortOut(PortOut)
`ifdef MIPS_IO_IRQ_EN
    , .irq(irq)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO as a queue, drain pacing as "earliest edge for next pop".
  logic [7:0]  q[$];
  int          edge_n = 0;
  int          next_pop = 0;
  logic [7:0]  m_out, m_s1, m_s2, m_s3;
  logic [15:0] m_div;
  bit          m_inch, m_ovf, m_irqen, m_irq;
  bit          model_valid = 1'b0;
  logic [7:0]  pin_hold = 8'h00;
  logic [31:0] rd_obs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, input bit re);
    logic [31:0] v;
    v = 32'd0;
    if (in_window(a) && re) begin
      case (a[3:2])
        2'd0: v = {24'd0, m_out};
        2'd1: v = {24'd0, m_s2};
        2'd2: begin
          v[12:8] = 5'(q.size());
          v[3]    = m_ovf;
          v[2]    = m_inch;
          v[1]    = (q.size() == 4);
          v[0]    = (q.size() == 0);
        end
        default: begin
          v[15:0] = m_div;
`ifdef MIPS_IO_IRQ_EN
          v[16]   = m_irqen;
`endif
        end
      endcase
    end
    return v;
  endfunction

  function automatic void model_edge(input bit rn, input bit we, input bit re,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     input logic [7:0] pin);
    bit hit, pop, full, sr, chg, ovf_set;
    logic [15:0] old_div;
    if (!rn) begin
      q.delete();
      next_pop = 0;
      m_out = 8'h00; m_div = 16'd0;
      m_s1 = 8'h00; m_s2 = 8'h00; m_s3 = 8'h00;
      m_inch = 1'b0; m_ovf = 1'b0; m_irqen = 1'b0; m_irq = 1'b0;
    end else begin
      hit     = in_window(a);
      pop     = (q.size() != 0) && (edge_n >= next_pop);
      full    = (q.size() == 4);
      old_div = m_div;
      sr      = hit && re && !we && (a[3:2] == 2'd2);
      chg     = (m_s2 != m_s3);
      ovf_set = 1'b0;
      m_irq   = m_irqen && (m_inch || m_ovf);
      if (pop) begin
        m_out    = q.pop_front();
        next_pop = edge_n + int'(old_div) + 1;
      end
      if (hit && we && a[3:2] == 2'd0) begin
        if (!full || pop) q.push_back(wd[7:0]);
        else ovf_set = 1'b1;
      end
      if (hit && we && a[3:2] == 2'd3) begin
        m_div   = wd[15:0];
        m_irqen = wd[16];
      end
      m_inch = chg || (m_inch && !sr);
      m_ovf  = ovf_set || (m_ovf && !sr);
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = pin;
    end
    edge_n++;
  endfunction

  task automatic step(input bit rn, input bit we, input bit re,
                      input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    reset = rn; MemWrite = we; MemRead = re;
    Address = a; WriteData = wd; PortIn = pin_hold;
    #1;
    rd_obs = ReadData;
    if (model_valid) begin
      check("MemHit", MemHit, in_window(a));
      check("ReadData", ReadData, exp_read(a, re));
      check("PortOut", PortOut, m_out);
`ifdef MIPS_IO_IRQ_EN
      check("irq", irq, m_irq);
`endif
    end
    @(posedge clk);
    model_edge(rn, we, re, a, wd, pin_hold);
    if (!rn) model_valid = 1'b1;
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    step(1'b1, 1'b1, 1'b0, BASE + 32'(off * 4), d);
  endtask

  task automatic rd(input int off);
    step(1'b1, 1'b0, 1'b1, BASE + 32'(off * 4), 32'd0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  logic [31:0] obs [6];

  initial begin
    reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    Address = 32'd0; WriteData = 32'd0; PortIn = 8'h00;

    do_reset(2);
    rd(2); check("t1_status", rd_obs, 32'h0000_0001);
    rd(3); check("t1_ctrl", rd_obs, 32'h0000_0000);

    wr(3, 32'd0);
    wr(0, 32'h0000_00A5);
    rd(0); check("t2_before", rd_obs, 32'h0000_0000);
    rd(0); check("t2_portout", rd_obs, 32'h0000_00A5);
    rd(2); check("t2_status", rd_obs, 32'h0000_0001);

    do_reset(2);
    wr(3, 32'd3);
    wr(0, 32'h11);
    wr(0, 32'h22);
    for (int i = 1; i <= 5; i++) begin
      rd(0);
      obs[i] = rd_obs;
    end
    check("t3_first", obs[1], 32'h11);
    check("t3_hold", obs[4], 32'h11);
    check("t3_second", obs[5], 32'h22);

    do_reset(2);
    wr(3, 32'h0000_FFFF);
    for (int i = 0; i < 6; i++) wr(0, 32'h31 + 32'(i));
    rd(2); check("t4_status", rd_obs, 32'h0000_040A);
    rd(2); check("t4_cleared", rd_obs, 32'h0000_0402);
    rd(0); check("t4_portout", rd_obs, 32'h0000_0031);

    do_reset(2);
    rd(2); check("t1_mid_status", rd_obs, 32'h0000_0001);
    rd(3); check("t1_mid_ctrl", rd_obs, 32'h0000_0000);
    rd(0); check("t1_mid_portout", rd_obs, 32'h0000_0000);

    pin_hold = 8'h3C;
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    rd(1); check("t5_early", rd_obs, 32'h0000_0000);
    rd(1); check("t5_in_data", rd_obs, 32'h0000_003C);
    rd(2); check("t5_changed", rd_obs, 32'h0000_0005);
    rd(2); check("t5_cleared", rd_obs, 32'h0000_0001);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, wd;
      bit rn, we, re;
      int kind;
      rn   = ($urandom_range(0, 199) != 0);
      kind = $urandom_range(0, 11);
      if (kind < 9)       a = BASE + 32'($urandom_range(0, 15));
      else if (kind == 9) a = BASE + 32'd16;
      else if (kind == 10) a = BASE - 32'd4;
      else                a = $urandom;
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 1) == 1);
      wd = $urandom;
      if ($urandom_range(0, 15) != 0) wd[15:0] = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) pin_hold = 8'($urandom);
      step(rn, we, re, a, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
